// File: rtl/controller_pkg.sv
// Shared types and constants for the serial controller responder.
package controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDrained
  } state_e;

  // Bit positions within the button vector; bit 0 goes out on the wire first.
  localparam int unsigned BtnA      = 0;
  localparam int unsigned BtnB      = 1;
  localparam int unsigned BtnSelect = 2;
  localparam int unsigned BtnStart  = 3;
  localparam int unsigned BtnUp     = 4;
  localparam int unsigned BtnDown   = 5;
  localparam int unsigned BtnLeft   = 6;
  localparam int unsigned BtnRight  = 7;

  localparam int unsigned NumButtonsDefault = 8;

endpackage

// File: rtl/sync_edge_m.sv
// Multi-flop synchronizer for an asynchronous pin, followed by rise/fall pulse detection.
module sync_edge_m #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  level;

  assign level = sync_q[SyncStages-1];

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
    prev_d = level;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/controller_responder_m.sv
// Device end of the latch/clock/serial-data controller protocol (8-bit PISO, active-low data).
// Optional autofire: define CONTROLLER_RESPONDER_TURBO_EN.
module controller_responder_m
  import controller_pkg::*;
#(
  parameter int unsigned NumButtons  = NumButtonsDefault,
  parameter int unsigned SyncStages  = 2,
  parameter bit          FillLevel   = 1'b1,
  parameter int unsigned TurboPeriod = 4,
  localparam int unsigned CntW       = $clog2(NumButtons + 1)
) (
  input  logic                  clk,
  input  logic                  rst_B,
  input  logic [NumButtons-1:0] buttons,
  input  logic [NumButtons-1:0] turbo_mask,
  input  logic                  latch,
  input  logic                  ctrl_clk,
  output logic                  data_out_B,
  output logic                  frame_strobe,
  output logic [CntW-1:0]       bit_count,
  output logic                  overrun
);

  logic latch_rise, latch_fall, ctrl_rise, unused_ctrl_fall;

  sync_edge_m #(.SyncStages(SyncStages)) u_sync_latch (
    .clk_i  (clk),
    .rst_ni (rst_B),
    .d_i    (latch),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  sync_edge_m #(.SyncStages(SyncStages)) u_sync_ctrl_clk (
    .clk_i  (clk),
    .rst_ni (rst_B),
    .d_i    (ctrl_clk),
    .rise_o (ctrl_rise),
    .fall_o (unused_ctrl_fall)
  );

  logic [NumButtons-1:0] eff_buttons;

`ifdef CONTROLLER_RESPONDER_TURBO_EN
  localparam int unsigned TcW = $clog2(TurboPeriod + 1);
  logic [TcW-1:0] turbo_cnt_q, turbo_cnt_d;
  logic           turbo_phase_q, turbo_phase_d;

  // Phase flips on the first latch after TurboPeriod latches, so each phase spans whole frames.
  always_comb begin
    turbo_cnt_d   = turbo_cnt_q;
    turbo_phase_d = turbo_phase_q;
    if (latch_rise) begin
      if (turbo_cnt_q == TcW'(TurboPeriod)) begin
        turbo_cnt_d   = TcW'(1);
        turbo_phase_d = ~turbo_phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + TcW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
    end
  end

  assign eff_buttons = buttons & ~(turbo_mask & {NumButtons{turbo_phase_d}});
`else
  logic unused_turbo;
  assign unused_turbo = (^turbo_mask) ^ (TurboPeriod != 0);
  assign eff_buttons  = buttons;
`endif

  state_e                state_q, state_d;
  logic [NumButtons-1:0] snapshot_q, snapshot_d;
  logic                  data_out_q, data_out_d;
  logic [CntW-1:0]       bit_count_q, bit_count_d;
  logic                  frame_strobe_q, frame_strobe_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d        = state_q;
    snapshot_d     = snapshot_q;
    data_out_d     = data_out_q;
    bit_count_d    = bit_count_q;
    overrun_d      = overrun_q;
    frame_strobe_d = 1'b0;
    // A latch rise pre-empts any ctrl_clk edge seen in the same cycle.
    if (latch_rise) begin
      state_d     = StLoad;
      snapshot_d  = eff_buttons;
      data_out_d  = ~eff_buttons[0];
      bit_count_d = '0;
      overrun_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: data_out_d = 1'b1;
        StLoad: begin
          snapshot_d = eff_buttons;
          data_out_d = ~eff_buttons[0];
          if (latch_fall) begin
            state_d        = StShift;
            frame_strobe_d = 1'b1;
          end
        end
        StShift: begin
          if (ctrl_rise) begin
            snapshot_d  = {FillLevel, snapshot_q[NumButtons-1:1]};
            bit_count_d = bit_count_q + CntW'(1);
            data_out_d  = ~snapshot_d[0];
            if (bit_count_d == CntW'(NumButtons)) state_d = StDrained;
          end
        end
        StDrained: begin
          data_out_d = ~FillLevel;
          if (ctrl_rise) overrun_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      state_q        <= StIdle;
      snapshot_q     <= '0;
      data_out_q     <= 1'b1;
      bit_count_q    <= '0;
      frame_strobe_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      snapshot_q     <= snapshot_d;
      data_out_q     <= data_out_d;
      bit_count_q    <= bit_count_d;
      frame_strobe_q <= frame_strobe_d;
      overrun_q      <= overrun_d;
    end
  end

  assign data_out_B   = data_out_q;
  assign frame_strobe = frame_strobe_q;
  assign bit_count    = bit_count_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/controller_responder_m.md
Name: controller_responder_m

Overview:
Serial game-controller responder: the device end of the console's latch/clock/serial-data controller protocol, behaving like an 8-bit parallel-in/serial-out controller shift register. Samples a parallel button vector on latch and shifts it out active-low, one bit per controller-clock rising edge. Used as a virtual controller, for example bridging a USB or keyboard adapter. Also serves as the bus-functional peer for controller_interface_m in integration benches.

Parameters:
NUM_BUTTONS, 8, number of serial bits per frame.
SYNC_STAGES, 2, synchronizer depth on latch and ctrl_clk (minimum 2).
FILL_LEVEL, 1, logical bit value presented after all NUM_BUTTONS bits are shifted (1 = pressed, so data_out_B=0).
TURBO_PERIOD, 4, latches per turbo half-period (used only with the optional feature).

Ports:
clk  input  1  block clock; asynchronous to latch and ctrl_clk; must be at least 8x the ctrl_clk frequency.
rst_B  input  1  asynchronous, active-low reset.
buttons  input  NUM_BUTTONS  live button state, active-high; bit 0 is shifted first.
turbo_mask  input  NUM_BUTTONS  per-button autofire enable; ignored without the macro.
latch  input  1  console latch, active-high, asynchronous.
ctrl_clk  input  1  console shift clock; a rising edge advances the shift register; asynchronous.
data_out_B  output  1  serial data, active-low (0 = pressed).
frame_strobe  output  1  one-cycle pulse on the synchronized latch falling edge (snapshot committed).
bit_count  output  $clog2(NUM_BUTTONS+1)  bits shifted since the last latch.
overrun  output  1  sticky flag: a ctrl_clk edge arrived after the frame was exhausted.

Behaviour:
- Reset (rst_B=0, asynchronous): state=IDLE, snapshot=0, data_out_B=1, bit_count=0, frame_strobe=0, overrun=0. Reset mid-frame abandons the frame; the next latch rise is required.
- latch and ctrl_clk pass through SYNC_STAGES flops, then rise/fall edge detectors (one extra flop).
- Latency: pin edge to data_out_B change is SYNC_STAGES+1 clk cycles (3 at default).
- States:
  - IDLE: data_out_B=1. ctrl_clk edges ignored.
  - LOAD: entered on latch rise from any state.
    - snapshot <= effective buttons every cycle (transparent, parallel mode).
    - data_out_B = ~snapshot[0]; bit_count=0; overrun cleared on entry.
    - ctrl_clk edges ignored.
  - SHIFT: entered on latch fall; frame_strobe pulses that cycle.
    - Each ctrl_clk rise: snapshot shifts right, FILL_LEVEL inserted at the MSB; bit_count+1; data_out_B = ~snapshot[0].
    - When bit_count reaches NUM_BUTTONS: go to DRAINED.
  - DRAINED: data_out_B = ~FILL_LEVEL; bit_count holds at NUM_BUTTONS. Each ctrl_clk rise sets overrun.
- Simultaneous latch rise and ctrl_clk rise in the same cycle: latch wins; the clock edge is dropped.
- A latch pulse shorter than one synchronized cycle may be missed; the console guarantees at least 2 clk cycles.
- bit_count saturates and never wraps.
- All outputs are registered.

Optional Feature:
CONTROLLER_RESPONDER_TURBO_EN
- Defined:
  - An internal latch-rise counter toggles a turbo phase every TURBO_PERIOD latches.
  - Effective buttons = buttons & ~(turbo_mask & {NUM_BUTTONS{turbo_phase}}).
  - The counter and phase reset to 0.
- Undefined: effective buttons = buttons; turbo_mask is unconnected internally; no counter logic.

Decomposition:
- controller_pkg:
  - state enum {IDLE, LOAD, SHIFT, DRAINED}.
  - Button index constants: A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7.
  - Default NUM_BUTTONS.
- Sub-module sync_edge_m: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated twice, for latch and ctrl_clk.

Test Plan:
- Basic frame: buttons=8'h05, latch pulse, 8 ctrl_clk pulses -> data_out_B sequence 0,1,0,1,1,1,1,1; frame_strobe pulses once; bit_count ends at 8.
- Exhaustion: 3 extra ctrl_clk pulses after the frame -> data_out_B stays 0 (FILL_LEVEL=1), overrun=1; next latch -> overrun=0.
- Latch dominance:
  - ctrl_clk toggled while latch high with buttons=8'h80 -> no shift, data_out_B=1, bit_count=0.
  - Latch and ctrl_clk rising on the same edge -> shift suppressed.
- Reset mid-frame: rst_B low after 3 shifts -> immediate data_out_B=1, bit_count=0, state IDLE; ctrl_clk ignored until latch.
- Integration: pair with controller_interface_m (one player). buttons=8'hA3 -> controller_1_buttons_out==8'hA3 after one fetch; random vectors over 100 frames match.
- Turbo (macro defined): turbo_mask=8'h01, buttons=8'h01, TURBO_PERIOD=4 -> bit 0 reads 1 for 4 frames, 0 for 4 frames, repeating. Without the macro: bit 0 reads 1 in every frame.
